// File: rtl/sa_icb_pkg.sv
// Shared types and helpers for the ICB memory responder: FSM state encoding,
// default lane geometry and the per-beat address legality check.
package sa_icb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WAIT  = 2'd2,
    RSP   = 2'd3
  } state_t;

  localparam int BYTE_LANES = 4;
  localparam int LANE_LOG2  = $clog2(BYTE_LANES);

  // Addresses arrive one bit wider than the bus so an overflowed beat address
  // still compares as out of range instead of wrapping back into memory.
  function automatic logic addr_ok(input logic [63:0] addr,
                                   input logic [63:0] base,
                                   input logic [63:0] depth,
                                   input int unsigned lane_log2);
    logic [63:0] lane_mask;
    logic [63:0] off;
    lane_mask = (64'd1 << lane_log2) - 64'd1;
    off       = addr - base;
    return (addr >= base) && ((addr & lane_mask) == 64'd0) && ((off >> lane_log2) < depth);
  endfunction

endpackage

// File: rtl/sa_icb_mem_array.sv
// Word array with per-byte write enables, one write port and a registered read port.
// Contents are never reset; only the read register is.
module sa_icb_mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_idx,
  input  logic [WIDTH-1:0]   wr_dat,
  input  logic [WIDTH/8-1:0] wr_mask,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_idx,
  output logic [WIDTH-1:0]   rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (wr_mask[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/sa_icb_mem_responder.sv
// ICB slave memory model: single outstanding burst, programmable response latency, range errors.
// Optional ready throttling by an LFSR when SA_ICB_MEM_BACKPRESSURE_EN is defined.
module sa_icb_mem_responder
  import sa_icb_pkg::*;
#(
  parameter int                    BUS_WIDTH   = 8 * BYTE_LANES,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    LEN_WIDTH   = 3,
  parameter int                    MEM_DEPTH   = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                    RSP_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   icb_cmd_valid,
  output logic                   icb_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]  icb_cmd_addr,
  input  logic                   icb_cmd_read,
  input  logic [LEN_WIDTH-1:0]   icb_cmd_len,
  input  logic [BUS_WIDTH-1:0]   icb_cmd_wdata,
  input  logic [BUS_WIDTH/8-1:0] icb_cmd_wmask,
  input  logic                   icb_w_valid,
  output logic                   icb_w_ready,
  output logic                   icb_rsp_valid,
  input  logic                   icb_rsp_ready,
  output logic [BUS_WIDTH-1:0]   icb_rsp_rdata,
  output logic                   icb_rsp_err
);

  localparam int LANES = BUS_WIDTH / 8;
  localparam int LLOG2 = (LANES == BYTE_LANES) ? LANE_LOG2 : $clog2(LANES);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   read_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_q;
  logic                   err_lat_q;
  logic [3:0]             wait_q;
  logic                   rsp_err_q;

  logic                   bp_block;
  logic                   cmd_hs, w_hs, rsp_hs;
  logic                   wait_done;
  logic                   last_beat;
  logic                   rd_en;
  logic [LEN_WIDTH-1:0]   sel_beat;
  logic [ADDR_WIDTH:0]    sel_addr;
  logic                   sel_ok;
  logic [IDX_W-1:0]       sel_idx;
  logic [BUS_WIDTH-1:0]   mem_rdata;

`ifdef SA_ICB_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign bp_block = lfsr_q[0];
`else
  assign bp_block = 1'b0;
`endif

  // The state register resets asynchronously to IDLE, so rst_n is folded in
  // to keep cmd_ready low for the whole reset window.
  assign icb_cmd_ready = rst_n & (state_q == IDLE) & ~bp_block;
  assign icb_w_ready   = (state_q == WDATA) & ~bp_block;
  assign icb_rsp_valid = (state_q == RSP);
  assign icb_rsp_err   = icb_rsp_valid & rsp_err_q;
  assign icb_rsp_rdata = (icb_rsp_valid && read_q && !rsp_err_q) ? mem_rdata : '0;

  assign cmd_hs    = icb_cmd_valid & icb_cmd_ready;
  assign w_hs      = icb_w_valid & icb_w_ready;
  assign rsp_hs    = icb_rsp_valid & icb_rsp_ready;
  assign last_beat = (beat_q == len_q);
  assign wait_done = ({1'b0, wait_q} + 5'd1) >= 5'(RSP_LATENCY);

  // In RSP the address path looks one beat ahead so the next read word is
  // already registered when the current beat is consumed.
  assign sel_beat = (state_q == RSP) ? beat_q + 1'b1 : beat_q;
  assign sel_addr = {1'b0, addr_q} + ({{(ADDR_WIDTH + 1 - LEN_WIDTH){1'b0}}, sel_beat} << LLOG2);
  assign sel_ok   = addr_ok(64'(sel_addr), 64'(BASE_ADDR), 64'(MEM_DEPTH), LLOG2);
  assign sel_idx  = IDX_W'((sel_addr - {1'b0, BASE_ADDR}) >> LLOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          state_d = icb_cmd_read ? WAIT : WDATA;
        end
      end
      WDATA: begin
        if (w_hs && last_beat) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_done) begin
          state_d = RSP;
          rd_en   = read_q;
        end
      end
      RSP: begin
        if (rsp_hs) begin
          if (!read_q || last_beat) begin
            state_d = IDLE;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      read_q    <= 1'b0;
      len_q     <= '0;
      beat_q    <= '0;
      err_lat_q <= 1'b0;
      wait_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            addr_q    <= icb_cmd_addr;
            read_q    <= icb_cmd_read;
            len_q     <= icb_cmd_len;
            beat_q    <= '0;
            err_lat_q <= 1'b0;
            wait_q    <= '0;
          end
        end
        WDATA: begin
          if (w_hs) begin
            err_lat_q <= err_lat_q | ~sel_ok;
            beat_q    <= last_beat ? '0 : beat_q + 1'b1;
          end
        end
        WAIT: begin
          if (wait_done) begin
            wait_q    <= '0;
            rsp_err_q <= read_q ? ~sel_ok : err_lat_q;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        RSP: begin
          if (rsp_hs && read_q && !last_beat) begin
            beat_q    <= beat_q + 1'b1;
            rsp_err_q <= ~sel_ok;
          end
        end
        default: ;
      endcase
    end
  end

  sa_icb_mem_array #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (MEM_DEPTH),
    .AW    (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_hs & sel_ok),
    .wr_idx  (sel_idx),
    .wr_dat  (icb_cmd_wdata),
    .wr_mask (icb_cmd_wmask),
    .rd_en   (rd_en),
    .rd_idx  (sel_idx),
    .rd_dat  (mem_rdata)
  );

endmodule

// File: tb/tb_sa_icb_mem_responder.sv
// Scoreboard bench for sa_icb_mem_responder: directed scenarios then randomized bursts,
// expectations from a word-indexed reference memory.
module tb_sa_icb_mem_responder;

  localparam int          BW    = 32;
  localparam int          AW    = 32;
  localparam int          LW    = 3;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          LAT_EXP = ((LAT < 1) ? 1 : LAT) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          icb_cmd_valid = 1'b0;
  logic          icb_cmd_ready;
  logic [AW-1:0] icb_cmd_addr = '0;
  logic          icb_cmd_read = 1'b0;
  logic [LW-1:0] icb_cmd_len = '0;
  logic [BW-1:0] icb_cmd_wdata = '0;
  logic [3:0]    icb_cmd_wmask = '0;
  logic          icb_w_valid = 1'b0;
  logic          icb_w_ready;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic [BW-1:0] icb_rsp_rdata;
  logic          icb_rsp_err;

  always #5 clk = ~clk;

  sa_icb_mem_responder #(
    .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .RSP_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read), .icb_cmd_len(icb_cmd_len),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_w_valid(icb_w_valid), .icb_w_ready(icb_w_ready),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk_data;
    bit          last;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model[int];
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          mon_en = 1'b0;
  bit          hold_rsp = 1'b0;
  bit          rand_rdy = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (hold_rsp)      icb_rsp_ready = 1'b0;
    else if (rand_rdy) icb_rsp_ready = ($urandom % 4) != 0;
    else               icb_rsp_ready = 1'b1;
  end

  function automatic longint beat_addr(input logic [31:0] addr, input int i);
    return longint'({32'b0, addr}) + longint'(i) * 4;
  endfunction

  function automatic bit beat_ok(input logic [31:0] addr, input int i);
    longint a;
    a = beat_addr(addr, i);
    return (a >= longint'({32'b0, BASE})) && (a < longint'({32'b0, BASE}) + longint'(DEPTH) * 4) && (a % 4 == 0);
  endfunction

  function automatic int word_of(input logic [31:0] addr, input int i);
    return int'((beat_addr(addr, i) - longint'({32'b0, BASE})) / 4);
  endfunction

  // Monitor: compares each consumed response against the scoreboard and checks
  // handshake rules (latency, hold stability, back-to-back beats, ready exclusivity).
  logic        pv, pr, pe;
  logic [31:0] pd;
  bit          pnl;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      pv = 1'b0; pr = 1'b0; pnl = 1'b0;
    end else begin
      if (icb_rsp_valid && !pv)
        chk((cyc - acc_cyc) == LAT_EXP, "rsp_latency", 64'(cyc - acc_cyc), 64'(LAT_EXP));
      if (pv && !pr)
        chk(icb_rsp_valid === 1'b1 && icb_rsp_rdata === pd && icb_rsp_err === pe, "rsp_hold_stable",
            {31'b0, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}, {32'b1, pe, pd});
      if (pnl)
        chk(icb_rsp_valid === 1'b1, "burst_back_to_back", 64'(icb_rsp_valid), 64'd1);
      if (icb_rsp_valid)
        chk(icb_cmd_ready === 1'b0 && icb_w_ready === 1'b0, "ready_low_in_rsp",
            {icb_cmd_ready, icb_w_ready}, 64'd0);
      pnl = 1'b0;
      if (icb_rsp_valid && icb_rsp_ready) begin
        if (sbq.size() == 0) begin
          chk(1'b0, "unexpected_rsp", {icb_rsp_err, icb_rsp_rdata}, 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk(icb_rsp_err === mon_e.err, "rsp_err", 64'(icb_rsp_err), 64'(mon_e.err));
          if (mon_e.chk_data)
            chk(icb_rsp_rdata === mon_e.rdata, "rsp_rdata", 64'(icb_rsp_rdata), 64'(mon_e.rdata));
          pnl = !mon_e.last;
        end
      end
      pv = icb_rsp_valid; pr = icb_rsp_ready; pd = icb_rsp_rdata; pe = icb_rsp_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input bit rd, input int len);
    bit   ok;
    exp_t e;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = addr;
    icb_cmd_read  = rd;
    icb_cmd_len   = 3'(len);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (icb_cmd_ready) begin ok = 1'b1; break; end
    end
    chk(ok, "cmd_accept_timeout", 64'(ok), 64'd1);
    acc_cyc = cyc;
    if (rd) begin
      for (int i = 0; i <= len; i++) begin
        e.err      = !beat_ok(addr, i);
        e.chk_data = e.err || model.exists(word_of(addr, i));
        e.rdata    = (!e.err && e.chk_data) ? model[word_of(addr, i)] : 32'd0;
        e.last     = (i == len);
        sbq.push_back(e);
      end
    end
    tick();
    icb_cmd_valid = 1'b0;
  endtask

  task automatic send_wbeat(input logic [31:0] addr, input int i, input logic [31:0] d,
                            input logic [3:0] m, input int gap, output bit berr);
    bit          ok;
    logic [31:0] w;
    int          idx;
    repeat (gap) tick();
    icb_w_valid   = 1'b1;
    icb_cmd_wdata = d;
    icb_cmd_wmask = m;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (icb_w_ready) begin ok = 1'b1; break; end
    end
    chk(ok, "w_accept_timeout", 64'(ok), 64'd1);
    berr = !beat_ok(addr, i);
    if (!berr) begin
      idx = word_of(addr, i);
      w = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
      for (int b = 0; b < 4; b++) if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
      if ($isunknown(w)) model.delete(idx);
      else model[idx] = w;
    end
    acc_cyc = cyc;
    tick();
    icb_w_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [31:0] d[$],
                          input logic [3:0] m[$], input int max_gap);
    bit   werr, berr;
    exp_t e;
    send_cmd(addr, 1'b0, len);
    werr = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == len) begin
        // push before the final handshake; the response cannot precede it
        e.rdata = 32'd0; e.chk_data = 1'b1; e.last = 1'b1;
        e.err = werr || !beat_ok(addr, i);
        sbq.push_back(e);
      end
      send_wbeat(addr, i, d[i], m[i], $urandom_range(0, max_gap), berr);
      werr |= berr;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !icb_rsp_valid) begin done = 1'b1; break; end
    end
    chk(done, "rsp_drain_timeout", 64'(sbq.size()), 64'd0);
    tick();
  endtask

  logic [31:0] dq[$];
  logic [3:0]  mq[$];
  logic [31:0] top_addr;
  logic [31:0] ra;
  bit          got, berr;

  initial begin
    top_addr = BASE + 32'((DEPTH - 1) * 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(icb_cmd_ready === 1'b0, "rst_cmd_ready", 64'(icb_cmd_ready), 64'd0);
    chk(icb_w_ready === 1'b0, "rst_w_ready", 64'(icb_w_ready), 64'd0);
    chk(icb_rsp_valid === 1'b0, "rst_rsp_valid", 64'(icb_rsp_valid), 64'd0);
    chk(icb_rsp_rdata === 32'd0 && icb_rsp_err === 1'b0, "rst_rsp_data", {icb_rsp_err, icb_rsp_rdata}, 64'd0);
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk(icb_cmd_ready === 1'b1, "idle_cmd_ready", 64'(icb_cmd_ready), 64'd1);
    tick();

    // single write then read
    do_write(BASE + 32'h10, 0, '{32'hDEADBEEF}, '{4'hF}, 0); drain();
    send_cmd(BASE + 32'h10, 1'b1, 0); drain();

    // preload 1..4 then burst read
    do_write(BASE, 3, '{32'd1, 32'd2, 32'd3, 32'd4}, '{4'hF, 4'hF, 4'hF, 4'hF}, 0); drain();
    send_cmd(BASE, 1'b1, 3); drain();

    // byte mask merge
    do_write(BASE + 32'h40, 0, '{32'h11223344}, '{4'hF}, 0); drain();
    do_write(BASE + 32'h40, 0, '{32'hAABBCCDD}, '{4'b0101}, 0); drain();
    send_cmd(BASE + 32'h40, 1'b1, 0); drain();
    do_write(BASE + 32'h40, 0, '{32'hFFFFFFFF}, '{4'h0}, 0); drain();
    send_cmd(BASE + 32'h40, 1'b1, 0); drain();

    // range edges: top crossing, misaligned, below base, address overflow
    do_write(top_addr, 0, '{32'hCAFEF00D}, '{4'hF}, 0); drain();
    send_cmd(top_addr, 1'b1, 1); drain();
    send_cmd(BASE + 32'h2, 1'b1, 0); drain();
    do_write(BASE + 32'h2, 0, '{32'h5555AAAA}, '{4'hF}, 0); drain();
    do_write(top_addr, 1, '{32'h01020304, 32'h05060708}, '{4'hF, 4'hF}, 0); drain();
    send_cmd(BASE - 32'h4, 1'b1, 0); drain();
    send_cmd(32'hFFFF_FFFC, 1'b1, 1); drain();

    // response backpressure held for 5 cycles
    hold_rsp = 1'b1;
    send_cmd(BASE, 1'b1, 3);
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (icb_rsp_valid) begin got = 1'b1; break; end
    end
    chk(got, "bp_rsp_timeout", 64'(got), 64'd1);
    for (int n = 0; n < 5; n++) begin
      chk(icb_rsp_valid === 1'b1 && icb_cmd_ready === 1'b0, "bp_hold_valid",
          {icb_rsp_valid, icb_cmd_ready}, 64'b10);
      chk(icb_rsp_rdata === model[0], "bp_hold_rdata", 64'(icb_rsp_rdata), 64'(model[0]));
      @(negedge clk);
    end
    hold_rsp = 1'b0;
    drain();

    // reset in the middle of a 4-beat write burst
    do_write(BASE + 32'h80, 3, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, '{4'hF, 4'hF, 4'hF, 4'hF}, 0); drain();
    send_cmd(BASE + 32'h80, 1'b0, 3);
    send_wbeat(BASE + 32'h80, 0, 32'hB0, 4'hF, 0, berr);
    send_wbeat(BASE + 32'h80, 1, 32'hB1, 4'hF, 0, berr);
    icb_w_valid = 1'b1;
    icb_cmd_wdata = 32'hB2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk(icb_cmd_ready === 1'b0 && icb_w_ready === 1'b0, "midrst_ready", {icb_cmd_ready, icb_w_ready}, 64'd0);
    chk(icb_rsp_valid === 1'b0 && icb_rsp_err === 1'b0 && icb_rsp_rdata === 32'd0, "midrst_rsp",
        {icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}, 64'd0);
    tick();
    icb_w_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk(icb_cmd_ready === 1'b1, "midrst_cmd_ready", 64'(icb_cmd_ready), 64'd1);
    mon_en = 1'b1;
    tick();
    send_cmd(BASE + 32'h80, 1'b1, 3); drain();

    // randomized traffic
    rand_rdy = 1'b1;
    for (int t = 0; t < 60; t++) begin
      int len;
      len = $urandom_range(0, 7);
      case ($urandom_range(0, 9))
        0:       ra = BASE + 32'($urandom_range(0, 63));
        1:       ra = BASE - 32'(4 * $urandom_range(1, 3));
        2, 3:    ra = BASE + 32'((DEPTH - $urandom_range(1, 6)) * 4);
        4:       ra = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        default: ra = BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      if ($urandom % 2) begin
        send_cmd(ra, 1'b1, len);
      end else begin
        dq.delete(); mq.delete();
        for (int i = 0; i <= len; i++) begin
          dq.push_back($urandom);
          mq.push_back(($urandom % 3 == 0) ? 4'($urandom) : 4'hF);
        end
        do_write(ra, len, dq, mq, 2);
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
